// File: rtl/i2s_audio_out.sv
// i2s_audio_out: 2-entry sample FIFO feeding a mono I2S transmitter.
// 12-bit offset-binary samples are converted to left-justified 16-bit two's
// complement words and sent in both the left and right slots of each frame.
module i2s_audio_out #(
  parameter int BCLK_DIV = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] sample_in,
  input  logic        sample_valid,
  output logic        sample_ready,
  output logic        i2s_bclk,
  output logic        i2s_lrclk,
  output logic        i2s_sdata,
  output logic        frame_start,
  output logic        underrun
);

  localparam int                DATA_W   = 12;
  localparam int                WORD_W   = 16;
  localparam logic [7:0]        DIV_LAST = 8'(BCLK_DIV - 1);
  localparam logic [DATA_W-1:0] SILENCE  = 12'h800;

  // Offset binary -> two's complement, left-justified into the 16-bit slot.
  function automatic logic signed [WORD_W-1:0] to_word(input logic [DATA_W-1:0] s);
    return {~s[DATA_W-1], s[DATA_W-2:0], 4'b0000};
  endfunction

  // Bit driven while bit_cnt = n. Slots are delayed by one BCLK, so n = 1..16
  // carries word[15..0] and n = 17..31 carries word[15..1]; n = 0 carries the
  // LSB of the word still held (the previous frame's right word).
  function automatic logic word_bit(input logic [WORD_W-1:0] w, input logic [4:0] n);
    logic [3:0] idx;
    if (n != 5'd0 && n <= 5'd16) idx = 4'(5'd16 - n);
    else                         idx = 4'(5'd0 - n);
    return w[idx];
  endfunction

  logic [7:0]               div_cnt;
  logic [4:0]               bit_cnt;
  logic [4:0]               bit_cnt_nxt;
  logic [1:0]               fifo_cnt;
  logic                     wr_ptr;
  logic                     rd_ptr;
  logic [DATA_W-1:0]        fifo_mem [2];
  logic [DATA_W-1:0]        held_sample;
  logic signed [WORD_W-1:0] word_cur;
  logic                     div_tc;
  logic                     bclk_fall;
  logic                     frame_wrap;
  logic                     push;
  logic                     pop;

  assign sample_ready = (fifo_cnt < 2'd2);
  assign push         = sample_valid & sample_ready;
  assign div_tc       = (div_cnt == DIV_LAST);
  assign bclk_fall    = div_tc & i2s_bclk;
  assign frame_wrap   = bclk_fall & (bit_cnt == 5'd31);
  assign pop          = frame_wrap & (fifo_cnt != 2'd0);
  assign bit_cnt_nxt  = bit_cnt + 5'd1;
  assign word_cur     = to_word(held_sample);

  // FIFO storage: written on accept only, contents qualified by fifo_cnt.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= sample_in;
  end

  // FIFO pointers and occupancy; simultaneous push/pop leaves count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      fifo_cnt <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // BCLK divider and bit clock generation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt  <= 8'd0;
      i2s_bclk <= 1'b0;
    end else if (div_tc) begin
      div_cnt  <= 8'd0;
      i2s_bclk <= ~i2s_bclk;
    end else begin
      div_cnt  <= div_cnt + 8'd1;
    end
  end

  // Bit position, word select and serial data all move on the BCLK fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt   <= 5'd0;
      i2s_lrclk <= 1'b0;
      i2s_sdata <= 1'b0;
    end else if (bclk_fall) begin
      bit_cnt   <= bit_cnt_nxt;
      i2s_lrclk <= bit_cnt_nxt[4];
      i2s_sdata <= word_bit(word_cur, bit_cnt_nxt);
    end
  end

  // Frame load: pop the FIFO head into the held sample, or flag underrun and
  // keep repeating the last sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held_sample <= SILENCE;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      frame_start <= frame_wrap;
      underrun    <= frame_wrap & (fifo_cnt == 2'd0);
      if (pop) held_sample <= fifo_mem[rd_ptr];
    end
  end

endmodule

// File: tb/tb_i2s_audio_out.sv
// tb_i2s_audio_out: vector table of sample->word conversions, corner-case
// sequences and a randomized phase, all checked cycle by cycle against a
// time-based reference model of the I2S frame.
module tb_i2s_audio_out;

  localparam int DIV   = 2;
  localparam int FRAME = 64 * DIV;

  logic        clk          = 1'b0;
  logic        rst_n        = 1'b1;
  logic [11:0] sample_in    = 12'h000;
  logic        sample_valid = 1'b0;
  logic        sample_ready;
  logic        i2s_bclk;
  logic        i2s_lrclk;
  logic        i2s_sdata;
  logic        frame_start;
  logic        underrun;

  i2s_audio_out #(.BCLK_DIV(DIV)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .i2s_bclk     (i2s_bclk),
    .i2s_lrclk    (i2s_lrclk),
    .i2s_sdata    (i2s_sdata),
    .frame_start  (frame_start),
    .underrun     (underrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: clk edges since reset release, queued samples,
  // currently playing sample, and the load/underrun events of this edge.
  int          t = 0;
  logic [11:0] q[$];
  logic [11:0] held = 12'h800;
  logic        exp_fs = 1'b0;
  logic        exp_ur = 1'b0;

  logic [15:0] cap_l = '0, cap_r = '0, last_left = '0, last_right = '0;
  logic        prev_bclk = 1'b0;
  int          ur_count = 0;
  int          rise_count = 0;

  typedef struct {
    logic [11:0] sample;
    logic [15:0] word;
  } vec_t;
  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, required %h (t=%0d)", name, act, req, t);
  endtask

  // Sample value in LSBs of full scale, scaled to a 16-bit left-justified word.
  function automatic logic [15:0] i2s_word(input logic [11:0] s);
    int v;
    v = (int'(s) - 2048) * 16;
    return v[15:0];
  endfunction

  function automatic logic [5:0] model_outputs();
    int          bc;
    logic [15:0] w;
    logic        sd;
    bc = (t / (2 * DIV)) % 32;
    w  = i2s_word(held);
    if (bc == 0)       sd = 1'b0;
    else if (bc <= 16) sd = w[16 - bc];
    else               sd = w[32 - bc];
    return {q.size() < 2, 1'((t / DIV) % 2), bc >= 16, sd, exp_fs, exp_ur};
  endfunction

  task automatic reset_model();
    t = 0;
    q.delete();
    held = 12'h800;
    exp_fs = 1'b0;
    exp_ur = 1'b0;
    prev_bclk = 1'b0;
  endtask

  task automatic tick(input logic v, input logic [11:0] d);
    logic ready_pre;
    int   bc;
    sample_valid = v;
    sample_in    = d;
    ready_pre    = (q.size() < 2);
    @(posedge clk);
    t++;
    exp_fs = (t % FRAME == 0);
    exp_ur = 1'b0;
    if (exp_fs) begin
      if (q.size() > 0) held = q.pop_front();
      else exp_ur = 1'b1;
    end
    if (v && ready_pre) q.push_back(d);
    #1;
    sample_valid = 1'b0;
    check("cycle {ready,bclk,lrclk,sdata,frame_start,underrun}",
          {sample_ready, i2s_bclk, i2s_lrclk, i2s_sdata, frame_start, underrun},
          model_outputs());
    if (i2s_bclk && !prev_bclk) begin
      rise_count++;
      bc = (t / (2 * DIV)) % 32;
      if (bc == 0) begin
        cap_r[0] = i2s_sdata;
        last_right = cap_r;
      end else if (bc <= 16) begin
        cap_l[16 - bc] = i2s_sdata;
        if (bc == 16) last_left = cap_l;
      end else begin
        cap_r[32 - bc] = i2s_sdata;
      end
    end
    prev_bclk = i2s_bclk;
    if (underrun) ur_count++;
  endtask

  task automatic wait_load(input string name);
    do tick(1'b0, 12'h000); while (!exp_fs);
    check({name, " frame_start"}, frame_start, 1'b1);
  endtask

  task automatic apply_reset();
    #2 rst_n = 1'b0;
    #1;
    check("outputs in reset", {sample_ready, i2s_bclk, i2s_lrclk, i2s_sdata, frame_start, underrun},
          6'b100000);
    sample_valid = 1'b1;
    sample_in    = 12'h5A5;
    repeat (3) @(posedge clk);
    sample_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    reset_model();
    #1;
    check("outputs after release", {sample_ready, i2s_bclk, i2s_lrclk, i2s_sdata, frame_start, underrun},
          6'b100000);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    vecs = '{'{12'hFFF, 16'h7FF0}, '{12'h000, 16'h8000}, '{12'h123, 16'h9230},
             '{12'hABC, 16'h2BC0}, '{12'h800, 16'h0000}, '{12'h7FF, 16'hFFF0}};

    apply_reset();

    // Idle after reset: silence, one underrun per frame, 32 BCLKs per frame.
    ur_count = 0;
    rise_count = 0;
    repeat (2 * FRAME) tick(1'b0, 12'h000);
    check("idle underrun pulses", ur_count, 2);
    check("idle bclk rises", rise_count, 64);

    // Vector table: single sample into empty FIFO, both slots carry its word.
    for (int i = 0; i < 6; i++) begin
      tick(1'b1, vecs[i].sample);
      wait_load("vec");
      check("vec no underrun", underrun, 1'b0);
      repeat (FRAME + DIV) tick(1'b0, 12'h000);
      check("vec left word", last_left, vecs[i].word);
      check("vec right word", last_right, vecs[i].word);
    end

    // Back-to-back pushes fill the FIFO; played in order.
    tick(1'b1, 12'h000);
    tick(1'b1, 12'h123);
    check("ready low when full", sample_ready, 1'b0);
    wait_load("b2b first");
    repeat (FRAME + DIV) tick(1'b0, 12'h000);
    check("b2b first left", last_left, 16'h8000);
    check("b2b first right", last_right, 16'h8000);
    repeat (FRAME) tick(1'b0, 12'h000);
    check("b2b second left", last_left, 16'h9230);
    check("b2b second right", last_right, 16'h9230);

    // Push on the exact load clock with one entry queued.
    tick(1'b1, 12'h7FF);
    while ((t + 1) % FRAME != 0) tick(1'b0, 12'h000);
    tick(1'b1, 12'hFFF);
    check("loadclk push frame_start", frame_start, 1'b1);
    check("loadclk push underrun", underrun, 1'b0);
    check("loadclk push ready (count 1)", sample_ready, 1'b1);
    wait_load("loadclk next");
    check("loadclk next underrun", underrun, 1'b0);
    check("loadclk prior frame left", last_left, 16'hFFF0);
    repeat (FRAME + DIV) tick(1'b0, 12'h000);
    check("loadclk pushed word left", last_left, 16'h7FF0);

    // Underrun repeats the last sample.
    tick(1'b1, 12'hABC);
    wait_load("repeat first");
    check("repeat first underrun", underrun, 1'b0);
    wait_load("repeat second");
    check("repeat second underrun", underrun, 1'b1);
    repeat (FRAME + DIV) tick(1'b0, 12'h000);
    check("repeat left", last_left, 16'h2BC0);
    check("repeat right", last_right, 16'h2BC0);

    // Reset mid-frame at bit_cnt 20 with the FIFO full.
    tick(1'b1, 12'h111);
    tick(1'b1, 12'h222);
    while ((t / (2 * DIV)) % 32 != 20) tick(1'b0, 12'h000);
    check("pre-reset lrclk", i2s_lrclk, 1'b1);
    check("pre-reset ready", sample_ready, 1'b0);
    apply_reset();
    wait_load("post-reset");
    check("post-reset underrun", underrun, 1'b1);
    repeat (FRAME + DIV) tick(1'b0, 12'h000);
    check("post-reset left", last_left, 16'h0000);
    check("post-reset right", last_right, 16'h0000);

    // Randomized traffic at several push rates.
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 1000; k++) begin
        tick($urandom_range(0, 99) < (r * 2 + 1), 12'($urandom));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/i2s_audio_out.md
I2S_AUDIO_OUT -- requirements
Module: i2s_audio_out

Interface
REQ-001 Parameter: BCLK_DIV, default 4, clk cycles per BCLK half-period; legal range 1..255.
REQ-002 clk  input  1  system clock (same domain as the synth main clock); all logic on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 sample_in  input  12  mixed synth sample, unsigned offset binary, 12'h800 = silence.
REQ-005 sample_valid  input  1  sample_in holds a new sample this cycle.
REQ-006 sample_ready  output  1  block accepts a sample this cycle; transfer = sample_valid & sample_ready.
REQ-007 i2s_bclk  output  1  I2S bit clock, registered.
REQ-008 i2s_lrclk  output  1  I2S word select: 0 = left, 1 = right; registered.
REQ-009 i2s_sdata  output  1  I2S serial data, MSB first; registered.
REQ-010 frame_start  output  1  one-clk pulse when a new frame word is loaded.
REQ-011 underrun  output  1  one-clk pulse, coincident with frame_start, when the FIFO was empty at load.

Function
REQ-012 Input buffer: 2-entry FIFO; sample_ready = (count < 2), derived from registered count only; no dependency on sample_valid.
REQ-013 Same-cycle push and pop: count unchanged, FIFO order preserved; push while full is impossible because ready is low.
REQ-014 BCLK divider: counter 0..BCLK_DIV-1; at terminal count it wraps to 0 and i2s_bclk toggles; one BCLK period = 2*BCLK_DIV clk.
REQ-015 Bit counter bit_cnt (5 bits, 0..31) advances on each i2s_bclk 1->0 toggle and wraps 31->0; one frame = 64*BCLK_DIV clk.
REQ-016 i2s_lrclk = 0 while bit_cnt is 0..15 and 1 while bit_cnt is 16..31; it updates on the same clk as bit_cnt.
REQ-017 Word format: word[15:0] = {~s[11], s[10:0], 4'b0000}, where s is the held sample (two's complement, left-justified).
REQ-018 Mono output: left and right slots both carry the same word.
REQ-019 I2S one-BCLK delay: at bit_cnt = n, with n in 1..16, sdata = word[16-n]; at n in 17..31, sdata = word[32-n].
REQ-020 At bit_cnt = 0, sdata = bit 0 of the previous frame's right word.
REQ-021 sdata changes only on the BCLK 1->0 edge, so it is stable across each BCLK rise.
REQ-022 Frame load: on the clk where bit_cnt wraps 31->0, the FIFO head is popped into the held sample (if count > 0) and frame_start pulses.
REQ-023 The new word's MSB first appears at bit_cnt = 1.
REQ-024 Underrun: if count = 0 at a frame load, the held sample is kept (last value repeated) and underrun pulses.
REQ-025 Latency: a sample accepted into an empty FIFO is loaded at the next 31->0 wrap.
REQ-026 The FIFO is popped at most once per frame.

Reset
REQ-027 While rst_n = 0, these values are forced asynchronously:
- i2s_bclk = 0, i2s_lrclk = 0, i2s_sdata = 0
- frame_start = 0, underrun = 0
- divider = 0, bit_cnt = 0, FIFO count = 0
- held sample = 12'h800
REQ-028 sample_ready = 1 during reset; samples presented during reset are not stored.
REQ-029 Reset mid-frame aborts the frame and discards FIFO contents.
REQ-030 After release, the first BCLK rise occurs BCLK_DIV clk after release.
REQ-031 After release, the first frame load occurs after a full frame of 32 BCLKs and carries silence (word 16'h0000).

Verification
REQ-032 BCLK_DIV=2, idle after reset -> i2s_bclk period 4 clk; i2s_lrclk period 128 clk; sdata all 0; underrun pulses once every 128 clk.
REQ-033 Push 12'hFFF then idle -> next frame word 16'h7FF0; left bits observed MSB..LSB = 0,1,1,1,1,1,1,1,1,1,1,1,0,0,0,0 at bit_cnt 1..16; right slot identical.
REQ-034 Push 12'h000 then 12'h123 back-to-back -> sample_ready falls after 2nd accept; frames carry 16'h8000 then 16'h9230.
REQ-035 With the FIFO at 1 entry, push on the exact frame-load clk -> count stays 1; pushed sample is output the following frame; no underrun.
REQ-036 Push 12'hABC, let one frame play, push nothing -> next frame repeats 16'h2BC0 and underrun pulses with frame_start.
REQ-037 Assert rst_n low at bit_cnt = 20 with 2 entries queued -> outputs zero immediately; after release, the first loaded word is 16'h0000 and sample_ready = 1.
